bus_arbiter_split: RTL and testbench
====================================

# bus_arbiter_split

Parametrised split-transaction bus arbiter for the shared serial bus. It grants the bus to one of `N_MASTERS` masters, organised into `N_GROUPS` fixed-priority groups with round-robin inside each group. It tracks up to `N_SLAVES` split slaves and reconnects each slave's owning master ahead of all new requests. A grant that is never picked up is revoked after a timeout. It replaces the fixed 12-master/6-slave controller in the bus top level.

## Interface

**Parameters**

- `N_MASTERS`, 12: number of masters. Must be a multiple of `N_GROUPS`.
- `N_GROUPS`, 3: number of priority groups. Group g holds masters g·M … g·M+M−1, with M = `N_MASTERS`/`N_GROUPS`. Group 0 has the highest priority.
- `N_SLAVES`, 6: number of split-capable slaves.
- `GRANT_TIMEOUT`, 16: cycles allowed for a master to pick up a grant, range 1 to 255.
- `MID_W`, $clog2(`N_MASTERS`+1): width of a master ID. The all-ones value is reserved as MID_NONE.

**Ports**

- `clk`, in, 1: the single clock. All logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `m_reqs`, in, `N_MASTERS`: per-master request level.
- `m_grants`, out, `N_MASTERS`: one-hot decode of the registered grant ID. All zero for MID_NONE.
- `bus_util`, in, 1: high while any master drives the bus.
- `slaves_in`, in, `N_SLAVES`: per-slave split-busy level.
- `slaves_out`, out, `N_SLAVES`: one-cycle reconnect acknowledge, one per slave.
- `mid_current`, out, `MID_W`: ID of the master that currently owns the bus, or MID_NONE.
- `state`, out, 3: FSM state, encoded as IDLE=0, SLV_BUSY=1, SEARCH=2, WAIT_FREE=3, WAIT_PICKUP=4, ACK=5.
- `timeout_err`, out, 1: one-cycle pulse when a grant is revoked by timeout.

## Operation

**Per-slave tracker**
- Each slave has a 2-bit state (FREE, BUSY, DONE) and an owner ID.
- FREE with `slaves_in`=1 → BUSY. The owner is set to `mid_current`, that master's block bit is set, and a `got_busy` flag is raised.
- BUSY with `slaves_in`=0 → DONE.
- These updates are evaluated every cycle, in every state.
- If several slaves go busy in the same cycle, all are recorded with the same owner.

**Eligibility and selection**
- A master is eligible when `m_reqs`[i]=1 and its block bit is 0.
- A master waiting on a split slave is never granted through the request path.
- Each group has a round-robin pointer. The winner within a group is the first eligible master at or after pointer+1, wrapping within the group.
- After a master is granted, its group's pointer is set to that master.

**FSM**
- IDLE, checked in this priority order:
  - `got_busy` → SLV_BUSY.
  - else any slave DONE → SEARCH with src=slave. The lowest-index DONE slave is chosen and its ID is latched in `sid_done`.
  - else the highest-priority group with an eligible master, provided it is strictly higher than the group of `mid_current` (or `mid_current`=MID_NONE) → SEARCH with src=master.
  - otherwise stay in IDLE.
  - In IDLE, if `bus_util`=0 then `mid_current` and the grant are cleared to MID_NONE.
- SLV_BUSY: clear the grant and `got_busy`. Stay until `bus_util`=0, then clear `mid_current` and go to IDLE.
- SEARCH: latch `mid_search` (the slave owner, or the round-robin winner) and clear the grant, which preempts the current master. Go to WAIT_FREE.
- WAIT_FREE: stay while `bus_util`=1. When `bus_util`=0, set `mid_current` and the grant to `mid_search`, load the timeout counter with 0, and go to WAIT_PICKUP.
- WAIT_PICKUP:
  - `bus_util`=1 and src=slave → ACK.
  - `bus_util`=1 and src=master → update that group's pointer and go to IDLE.
  - If the counter reaches `GRANT_TIMEOUT`−1 without pickup: clear the grant and `mid_current`, pulse `timeout_err`, go to IDLE. A slave in DONE stays DONE and is retried.
- ACK: assert `slaves_out`[`sid_done`] for exactly one cycle. Set that slave to FREE with owner MID_NONE, clear the owner's block bit, and go to IDLE.

## Timing

**Reset values**
- `state`=IDLE.
- Grant and `mid_current` = MID_NONE, so `m_grants`=0.
- `slaves_out`=0 and `timeout_err`=0.
- All slaves FREE, all block bits 0.
- Every round-robin pointer = last master of its group, so the group's first master wins first.
- `rst` asserted mid-operation forces these values immediately and drops any grant or acknowledge in progress.

**Latency**
- A request is seen in IDLE at edge k on an idle bus: SEARCH at k+1, WAIT_FREE at k+2, `m_grants` high after edge k+3.
- A slave DONE sampled at edge k on an idle bus: grant after k+3, `slaves_out` pulse in the cycle after pickup is seen.

**Other rules**
- `m_grants` is a combinational decode of a register and is glitch-free with respect to state.
- `slaves_in` changes take effect one edge after sampling.
- The timeout counter is 8 bits and never wraps; it saturates at `GRANT_TIMEOUT`−1.

## Test plan

1. Reset, then `m_reqs`=0x001 with the bus idle → `m_grants`=0x001 3 cycles later. The master raises `bus_util` → `state`=IDLE, `mid_current`=0.
2. Round-robin: masters 4 and 5 hold requests, each releases after 2 cycles → grants alternate 0x010, 0x020, 0x010.
3. Preemption: master 9 owns the bus and master 2 requests → grant to 9 drops in SEARCH. After `bus_util` falls, `m_grants`=0x004.
4. Split: master 1 owns the bus and `slaves_in`[3] rises → SLV_BUSY, grant dropped, master 1 blocked while it keeps requesting. `slaves_in`[3] falls → master 1 re-granted, then `slaves_out`[3] pulses for 1 cycle, and slave 3 and master 1 are freed.
5. Timeout (`GRANT_TIMEOUT`=4): master 0 is granted and never raises `bus_util` → grant drops after 4 cycles in WAIT_PICKUP and `timeout_err` pulses once.
6. Slaves 2 and 4 go DONE in the same cycle → slave 2's owner is serviced first, then slave 4's. Assert `rst` during the second ACK → all outputs return to reset values at once.

Source files
------------

// File: rtl/bus_arbiter_split.sv
// Split-transaction bus arbiter: fixed-priority groups with round-robin inside each group,
// split-slave reconnect ahead of new requests, and a grant pickup timeout.
module bus_arbiter_split #(
    parameter int N_MASTERS     = 12,
    parameter int N_GROUPS      = 3,
    parameter int N_SLAVES      = 6,
    parameter int GRANT_TIMEOUT = 16,
    parameter int MID_W         = $clog2(N_MASTERS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] m_reqs,
    output logic [N_MASTERS-1:0] m_grants,
    input  logic                 bus_util,
    input  logic [N_SLAVES-1:0]  slaves_in,
    output logic [N_SLAVES-1:0]  slaves_out,
    output logic [MID_W-1:0]     mid_current,
    output logic [2:0]           state,
    output logic                 timeout_err
);
    localparam int M  = N_MASTERS / N_GROUPS;
    localparam int PW = (M > 1) ? $clog2(M) : 1;
    localparam int GW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam logic [MID_W-1:0] MID_NONE = '1;
    localparam logic [MID_W-1:0] MID_LIM  = MID_W'(N_MASTERS);
    localparam logic [7:0]       TMO_LAST = 8'(GRANT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SLV_BUSY    = 3'd1,
        SEARCH      = 3'd2,
        WAIT_FREE   = 3'd3,
        WAIT_PICKUP = 3'd4,
        ACK         = 3'd5
    } state_t;

    typedef enum logic [1:0] {S_FREE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} slv_t;

    state_t               state_q, state_d;
    logic [MID_W-1:0]     grant_q, grant_d, cur_q, cur_d, search_q, search_d;
    logic                 src_slave_q, src_slave_d;
    logic [SW-1:0]        sid_q, sid_d;
    logic [GW-1:0]        sgrp_q, sgrp_d;
    logic [PW-1:0]        soff_q, soff_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 got_busy_q, got_busy_d;
    logic                 tmo_q, tmo_d;
    logic [N_MASTERS-1:0] block_q, block_d;
    slv_t                 slv_q [N_SLAVES];
    slv_t                 slv_d [N_SLAVES];
    logic [MID_W-1:0]     own_q [N_SLAVES];
    logic [MID_W-1:0]     own_d [N_SLAVES];
    logic [PW-1:0]        ptr_q [N_GROUPS];
    logic [PW-1:0]        ptr_d [N_GROUPS];

    logic [N_MASTERS-1:0] elig;
    logic                 req_hit, req_win, any_done;
    logic [GW-1:0]        best_grp, cur_grp;
    logic [PW-1:0]        best_off;
    logic [MID_W-1:0]     win_id, idx;
    logic [SW-1:0]        done_sid;
    int                   off;

    // Candidate selection: lowest group with an eligible master, rotating from pointer+1 inside it.
    always_comb begin
        elig     = m_reqs & ~block_q;
        req_hit  = 1'b0;
        best_grp = '0;
        best_off = '0;
        off      = 0;
        idx      = '0;
        for (int g = 0; g < N_GROUPS; g++) begin
            for (int k = 1; k <= M; k++) begin
                off = (int'(ptr_q[g]) + k) % M;
                idx = MID_W'(g * M + off);
                if (!req_hit && elig[idx]) begin
                    req_hit  = 1'b1;
                    best_grp = GW'(g);
                    best_off = PW'(off);
                end
            end
        end
        win_id  = MID_W'(int'(best_grp) * M + int'(best_off));
        cur_grp = '0;
        for (int g = 0; g < N_GROUPS; g++) begin
            if (cur_q >= MID_W'(g * M) && cur_q < MID_W'((g + 1) * M))
                cur_grp = GW'(g);
        end
        req_win  = req_hit && ((cur_q == MID_NONE) || (best_grp < cur_grp));
        any_done = 1'b0;
        done_sid = '0;
        for (int s = 0; s < N_SLAVES; s++) begin
            if (!any_done && slv_q[s] == S_DONE) begin
                any_done = 1'b1;
                done_sid = SW'(s);
            end
        end
    end

    // Next-state logic; the slave tracker runs last so a new split always wins over an ACK release.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cur_d       = cur_q;
        search_d    = search_q;
        src_slave_d = src_slave_q;
        sid_d       = sid_q;
        sgrp_d      = sgrp_q;
        soff_d      = soff_q;
        cnt_d       = cnt_q;
        got_busy_d  = got_busy_q;
        tmo_d       = 1'b0;
        block_d     = block_q;
        slv_d       = slv_q;
        own_d       = own_q;
        ptr_d       = ptr_q;
        case (state_q)
            IDLE: begin
                if (!bus_util) begin
                    cur_d   = MID_NONE;
                    grant_d = MID_NONE;
                end
                if (got_busy_q) begin
                    state_d = SLV_BUSY;
                end else if (any_done) begin
                    state_d     = SEARCH;
                    src_slave_d = 1'b1;
                    sid_d       = done_sid;
                    search_d    = own_q[done_sid];
                end else if (req_win) begin
                    state_d     = SEARCH;
                    src_slave_d = 1'b0;
                    sgrp_d      = best_grp;
                    soff_d      = best_off;
                    search_d    = win_id;
                end
            end
            SLV_BUSY: begin
                grant_d    = MID_NONE;
                got_busy_d = 1'b0;
                if (!bus_util) begin
                    cur_d   = MID_NONE;
                    state_d = IDLE;
                end
            end
            SEARCH: begin
                grant_d = MID_NONE;
                state_d = WAIT_FREE;
            end
            WAIT_FREE: begin
                if (!bus_util) begin
                    cur_d   = search_q;
                    grant_d = search_q;
                    cnt_d   = '0;
                    state_d = WAIT_PICKUP;
                end
            end
            WAIT_PICKUP: begin
                if (bus_util) begin
                    if (src_slave_q) begin
                        state_d = ACK;
                    end else begin
                        ptr_d[sgrp_q] = soff_q;
                        state_d       = IDLE;
                    end
                end else if (cnt_q >= TMO_LAST) begin
                    grant_d = MID_NONE;
                    cur_d   = MID_NONE;
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ACK: begin
                slv_d[sid_q] = S_FREE;
                own_d[sid_q] = MID_NONE;
                if (own_q[sid_q] < MID_LIM)
                    block_d[own_q[sid_q]] = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        for (int s = 0; s < N_SLAVES; s++) begin
            case (slv_q[s])
                S_FREE: begin
                    if (slaves_in[s]) begin
                        slv_d[s]   = S_BUSY;
                        own_d[s]   = cur_q;
                        got_busy_d = 1'b1;
                        if (cur_q < MID_LIM)
                            block_d[cur_q] = 1'b1;
                    end
                end
                S_BUSY: if (!slaves_in[s]) slv_d[s] = S_DONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= MID_NONE;
            cur_q       <= MID_NONE;
            search_q    <= MID_NONE;
            src_slave_q <= 1'b0;
            sid_q       <= '0;
            sgrp_q      <= '0;
            soff_q      <= '0;
            cnt_q       <= '0;
            got_busy_q  <= 1'b0;
            tmo_q       <= 1'b0;
            block_q     <= '0;
            for (int s = 0; s < N_SLAVES; s++) begin
                slv_q[s] <= S_FREE;
                own_q[s] <= MID_NONE;
            end
            for (int g = 0; g < N_GROUPS; g++)
                ptr_q[g] <= PW'(M - 1);
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cur_q       <= cur_d;
            search_q    <= search_d;
            src_slave_q <= src_slave_d;
            sid_q       <= sid_d;
            sgrp_q      <= sgrp_d;
            soff_q      <= soff_d;
            cnt_q       <= cnt_d;
            got_busy_q  <= got_busy_d;
            tmo_q       <= tmo_d;
            block_q     <= block_d;
            slv_q       <= slv_d;
            own_q       <= own_d;
            ptr_q       <= ptr_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N_MASTERS; i++)
            m_grants[i] = (grant_q == MID_W'(i));
        slaves_out = '0;
        if (state_q == ACK)
            slaves_out[sid_q] = 1'b1;
    end

    assign mid_current = cur_q;
    assign state       = state_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_bus_arbiter_split.sv
// Directed bench for bus_arbiter_split: cycle tables for grant/round-robin/preemption,
// hand-written sequences for split reconnect, pickup timeout and reset during ACK.
module tb_bus_arbiter_split;
    localparam int NM = 12;
    localparam int NS = 6;
    localparam int MW = 4;
    localparam logic [MW-1:0] NONE = 4'hF;

    logic          clk = 1'b0;
    logic          rst;
    logic [NM-1:0] m_reqs;
    logic [NM-1:0] m_grants;
    logic          bus_util;
    logic [NS-1:0] slaves_in;
    logic [NS-1:0] slaves_out;
    logic [MW-1:0] mid_current;
    logic [2:0]    state;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_arbiter_split #(
        .N_MASTERS(12), .N_GROUPS(3), .N_SLAVES(6), .GRANT_TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst), .m_reqs(m_reqs), .m_grants(m_grants),
        .bus_util(bus_util), .slaves_in(slaves_in), .slaves_out(slaves_out),
        .mid_current(mid_current), .state(state), .timeout_err(timeout_err)
    );

    typedef struct {
        logic [NM-1:0] reqs;
        logic          bu;
        logic [NS-1:0] sin;
        logic [NM-1:0] g;
        logic [2:0]    st;
        logic [MW-1:0] mid;
        logic [NS-1:0] so;
        logic          tmo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [NM-1:0] r, input logic b, input logic [NM-1:0] g,
                                input logic [2:0] st, input logic [MW-1:0] mid);
        vec_t v;
        v.reqs = r; v.bu = b; v.sin = '0; v.g = g; v.st = st; v.mid = mid; v.so = '0; v.tmo = 1'b0;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [NM-1:0] eg, input logic [2:0] est,
                               input logic [MW-1:0] emid, input logic [NS-1:0] eso, input logic etmo);
        checks++;
        if (m_grants !== eg) begin
            errors++;
            $display("[TB] FAIL %s m_grants got %h want %h", name, m_grants, eg);
        end
        checks++;
        if (state !== est) begin
            errors++;
            $display("[TB] FAIL %s state got %0d want %0d", name, state, est);
        end
        checks++;
        if (mid_current !== emid) begin
            errors++;
            $display("[TB] FAIL %s mid_current got %h want %h", name, mid_current, emid);
        end
        checks++;
        if (slaves_out !== eso) begin
            errors++;
            $display("[TB] FAIL %s slaves_out got %h want %h", name, slaves_out, eso);
        end
        checks++;
        if (timeout_err !== etmo) begin
            errors++;
            $display("[TB] FAIL %s timeout_err got %b want %b", name, timeout_err, etmo);
        end
    endtask

    task automatic applyStimulus(input logic [NM-1:0] r, input logic b, input logic [NS-1:0] s);
        m_reqs    = r;
        bus_util  = b;
        slaves_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name, input logic [NM-1:0] r, input logic b, input logic [NS-1:0] s,
                        input logic [NM-1:0] eg, input logic [2:0] est, input logic [MW-1:0] emid,
                        input logic [NS-1:0] eso, input logic etmo);
        applyStimulus(r, b, s);
        checkOutput(name, eg, est, emid, eso, etmo);
    endtask

    initial begin
        // single grant, round-robin in group 1, preemption of group 2 by group 0
        vecs.push_back(mk(12'h001, 0, 12'h000, 2, NONE));
        vecs.push_back(mk(12'h001, 0, 12'h000, 3, NONE));
        vecs.push_back(mk(12'h001, 0, 12'h001, 4, 4'd0));
        vecs.push_back(mk(12'h001, 1, 12'h001, 0, 4'd0));
        vecs.push_back(mk(12'h000, 1, 12'h001, 0, 4'd0));
        vecs.push_back(mk(12'h000, 0, 12'h000, 0, NONE));
        vecs.push_back(mk(12'h030, 0, 12'h000, 2, NONE));
        vecs.push_back(mk(12'h030, 0, 12'h000, 3, NONE));
        vecs.push_back(mk(12'h030, 0, 12'h010, 4, 4'd4));
        vecs.push_back(mk(12'h030, 1, 12'h010, 0, 4'd4));
        vecs.push_back(mk(12'h030, 1, 12'h010, 0, 4'd4));
        vecs.push_back(mk(12'h030, 0, 12'h000, 0, NONE));
        vecs.push_back(mk(12'h030, 0, 12'h000, 2, NONE));
        vecs.push_back(mk(12'h030, 0, 12'h000, 3, NONE));
        vecs.push_back(mk(12'h030, 0, 12'h020, 4, 4'd5));
        vecs.push_back(mk(12'h030, 1, 12'h020, 0, 4'd5));
        vecs.push_back(mk(12'h030, 1, 12'h020, 0, 4'd5));
        vecs.push_back(mk(12'h030, 0, 12'h000, 0, NONE));
        vecs.push_back(mk(12'h030, 0, 12'h000, 2, NONE));
        vecs.push_back(mk(12'h030, 0, 12'h000, 3, NONE));
        vecs.push_back(mk(12'h030, 0, 12'h010, 4, 4'd4));
        vecs.push_back(mk(12'h030, 1, 12'h010, 0, 4'd4));
        vecs.push_back(mk(12'h000, 0, 12'h000, 0, NONE));
        vecs.push_back(mk(12'h200, 0, 12'h000, 2, NONE));
        vecs.push_back(mk(12'h200, 0, 12'h000, 3, NONE));
        vecs.push_back(mk(12'h200, 0, 12'h200, 4, 4'd9));
        vecs.push_back(mk(12'h200, 1, 12'h200, 0, 4'd9));
        vecs.push_back(mk(12'h204, 1, 12'h200, 2, 4'd9));
        vecs.push_back(mk(12'h204, 1, 12'h000, 3, 4'd9));
        vecs.push_back(mk(12'h204, 1, 12'h000, 3, 4'd9));
        vecs.push_back(mk(12'h004, 0, 12'h004, 4, 4'd2));
        vecs.push_back(mk(12'h004, 1, 12'h004, 0, 4'd2));
        vecs.push_back(mk(12'h000, 0, 12'h000, 0, NONE));

        rst = 1'b1; m_reqs = '0; bus_util = 1'b0; slaves_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 12'h000, 3'd0, NONE, 6'h00, 1'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].reqs, vecs[i].bu, vecs[i].sin);
            checkOutput($sformatf("vec%0d", i), vecs[i].g, vecs[i].st, vecs[i].mid, vecs[i].so, vecs[i].tmo);
        end

        // split on slave 3 while master 1 owns the bus
        step("split_req",   12'h002, 0, 6'h00, 12'h000, 2, NONE, 6'h00, 0);
        step("split_wf",    12'h002, 0, 6'h00, 12'h000, 3, NONE, 6'h00, 0);
        step("split_grant", 12'h002, 0, 6'h00, 12'h002, 4, 4'd1, 6'h00, 0);
        step("split_own",   12'h002, 1, 6'h00, 12'h002, 0, 4'd1, 6'h00, 0);
        step("split_rise",  12'h002, 1, 6'h08, 12'h002, 0, 4'd1, 6'h00, 0);
        step("split_busy",  12'h002, 1, 6'h08, 12'h002, 1, 4'd1, 6'h00, 0);
        step("split_drop",  12'h002, 1, 6'h08, 12'h000, 1, 4'd1, 6'h00, 0);
        step("split_idle",  12'h002, 0, 6'h08, 12'h000, 0, NONE, 6'h00, 0);
        step("split_blk1",  12'h002, 0, 6'h08, 12'h000, 0, NONE, 6'h00, 0);
        step("split_blk2",  12'h002, 0, 6'h08, 12'h000, 0, NONE, 6'h00, 0);
        step("split_done",  12'h002, 0, 6'h00, 12'h000, 0, NONE, 6'h00, 0);
        step("split_srch",  12'h002, 0, 6'h00, 12'h000, 2, NONE, 6'h00, 0);
        step("split_wf2",   12'h002, 0, 6'h00, 12'h000, 3, NONE, 6'h00, 0);
        step("split_regnt", 12'h002, 0, 6'h00, 12'h002, 4, 4'd1, 6'h00, 0);
        step("split_ack",   12'h002, 1, 6'h00, 12'h002, 5, 4'd1, 6'h08, 0);
        step("split_ackend",12'h002, 1, 6'h00, 12'h002, 0, 4'd1, 6'h00, 0);
        step("split_rel",   12'h002, 0, 6'h00, 12'h000, 0, NONE, 6'h00, 0);
        step("unblk_srch",  12'h002, 0, 6'h00, 12'h000, 2, NONE, 6'h00, 0);
        step("unblk_wf",    12'h002, 0, 6'h00, 12'h000, 3, NONE, 6'h00, 0);
        step("unblk_grant", 12'h002, 0, 6'h00, 12'h002, 4, 4'd1, 6'h00, 0);
        step("unblk_own",   12'h002, 1, 6'h00, 12'h002, 0, 4'd1, 6'h00, 0);
        step("unblk_rel",   12'h000, 0, 6'h00, 12'h000, 0, NONE, 6'h00, 0);

        // grant never picked up: four cycles in WAIT_PICKUP, then revoke
        step("tmo_req",   12'h001, 0, 6'h00, 12'h000, 2, NONE, 6'h00, 0);
        step("tmo_wf",    12'h001, 0, 6'h00, 12'h000, 3, NONE, 6'h00, 0);
        step("tmo_grant", 12'h001, 0, 6'h00, 12'h001, 4, 4'd0, 6'h00, 0);
        step("tmo_w1",    12'h000, 0, 6'h00, 12'h001, 4, 4'd0, 6'h00, 0);
        step("tmo_w2",    12'h000, 0, 6'h00, 12'h001, 4, 4'd0, 6'h00, 0);
        step("tmo_w3",    12'h000, 0, 6'h00, 12'h001, 4, 4'd0, 6'h00, 0);
        step("tmo_fire",  12'h000, 0, 6'h00, 12'h000, 0, NONE, 6'h00, 1);
        step("tmo_after", 12'h000, 0, 6'h00, 12'h000, 0, NONE, 6'h00, 0);

        // slaves 2 and 4 split under master 6, serviced lowest index first; reset lands in second ACK
        step("dual_req",   12'h040, 0, 6'h00, 12'h000, 2, NONE, 6'h00, 0);
        step("dual_wf",    12'h040, 0, 6'h00, 12'h000, 3, NONE, 6'h00, 0);
        step("dual_grant", 12'h040, 0, 6'h00, 12'h040, 4, 4'd6, 6'h00, 0);
        step("dual_own",   12'h040, 1, 6'h00, 12'h040, 0, 4'd6, 6'h00, 0);
        step("dual_rise",  12'h040, 1, 6'h14, 12'h040, 0, 4'd6, 6'h00, 0);
        step("dual_busy",  12'h040, 1, 6'h14, 12'h040, 1, 4'd6, 6'h00, 0);
        step("dual_idle",  12'h040, 0, 6'h14, 12'h000, 0, NONE, 6'h00, 0);
        step("dual_done",  12'h040, 0, 6'h00, 12'h000, 0, NONE, 6'h00, 0);
        step("dual_s2",    12'h040, 0, 6'h00, 12'h000, 2, NONE, 6'h00, 0);
        step("dual_wf2",   12'h040, 0, 6'h00, 12'h000, 3, NONE, 6'h00, 0);
        step("dual_g2",    12'h040, 0, 6'h00, 12'h040, 4, 4'd6, 6'h00, 0);
        step("dual_ack2",  12'h040, 1, 6'h00, 12'h040, 5, 4'd6, 6'h04, 0);
        step("dual_post2", 12'h040, 1, 6'h00, 12'h040, 0, 4'd6, 6'h00, 0);
        step("dual_s4",    12'h040, 0, 6'h00, 12'h000, 2, NONE, 6'h00, 0);
        step("dual_wf4",   12'h040, 0, 6'h00, 12'h000, 3, NONE, 6'h00, 0);
        step("dual_g4",    12'h040, 0, 6'h00, 12'h040, 4, 4'd6, 6'h00, 0);
        step("dual_ack4",  12'h040, 1, 6'h00, 12'h040, 5, 4'd6, 6'h10, 0);

        rst = 1'b1;
        #1;
        checkOutput("rst_in_ack", 12'h000, 3'd0, NONE, 6'h00, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_idle",  12'h000, 0, 6'h00, 12'h000, 0, NONE, 6'h00, 0);
        step("post_req",   12'h040, 0, 6'h00, 12'h000, 2, NONE, 6'h00, 0);
        step("post_wf",    12'h040, 0, 6'h00, 12'h000, 3, NONE, 6'h00, 0);
        step("post_grant", 12'h040, 0, 6'h00, 12'h040, 4, 4'd6, 6'h00, 0);
        step("post_own",   12'h000, 1, 6'h00, 12'h040, 0, 4'd6, 6'h00, 0);
        step("post_rel",   12'h000, 0, 6'h00, 12'h000, 0, NONE, 6'h00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
